uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_param
// Brief   : Parameterised UART receiver (data bits, parity, stop bits).
//           Break detection is built only when UART_RX_BREAK_DETECT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy,
    output logic                 o_Break
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID   = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_CLEANUP   = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    state_t                r_State;
    state_t                w_State_Next;
    logic                  r_Rx_Meta;
    logic                  r_Rx_Sync;
    logic [c_CNT_W-1:0]    r_Cnt;
    logic [c_IDX_W-1:0]    r_Idx;
    logic [DATA_BITS-1:0]  r_Shift;
    logic                  r_Par_Bit;
    logic                  r_Stop_Err;
    logic                  r_Rx_DV;
    logic [DATA_BITS-1:0]  r_Rx_Data;
    logic                  r_Parity_Err;
    logic                  r_Frame_Err;
    logic                  w_Slot_End;
    logic                  w_Last_Stop;
    logic                  w_Par_Xor;
    logic                  w_Par_Err;

    assign w_Slot_End  = (r_Cnt == c_CNT_LAST);
    assign w_Last_Stop = (r_State == S_STOP) && w_Slot_End && (r_Idx == c_STOP_LAST);
    assign w_Par_Xor   = (^r_Shift) ^ r_Par_Bit;
    assign w_Par_Err   = (PARITY == 1) ? w_Par_Xor :
                         (PARITY == 2) ? ~w_Par_Xor : 1'b0;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_State_Next;
        end
    end

    always_comb begin
        w_State_Next = S_IDLE;
        case (r_State)
            S_IDLE:      w_State_Next = r_Rx_Sync ? S_IDLE : S_START;
            S_START: begin
                w_State_Next = S_START;
                // Mid-start-bit recheck rejects short low glitches.
                if (r_Cnt == c_CNT_MID) begin
                    w_State_Next = r_Rx_Sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                w_State_Next = S_DATA;
                if (w_Slot_End && (r_Idx == c_DATA_LAST)) begin
                    w_State_Next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY:    w_State_Next = w_Slot_End ? S_STOP : S_PARITY;
            S_STOP:      w_State_Next = w_Last_Stop ? S_CLEANUP : S_STOP;
            S_CLEANUP:   w_State_Next = r_Frame_Err ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: w_State_Next = r_Rx_Sync ? S_IDLE : S_WAIT_HIGH;
            default:     w_State_Next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Rx_Meta    <= 1'b1;
            r_Rx_Sync    <= 1'b1;
            r_Cnt        <= '0;
            r_Idx        <= '0;
            r_Shift      <= '0;
            r_Par_Bit    <= 1'b0;
            r_Stop_Err   <= 1'b0;
            r_Rx_DV      <= 1'b0;
            r_Rx_Data    <= '0;
            r_Parity_Err <= 1'b0;
            r_Frame_Err  <= 1'b0;
        end else begin
            r_Rx_Meta <= i_Rx_Serial;
            r_Rx_Sync <= r_Rx_Meta;
            r_Rx_DV   <= 1'b0;
            case (r_State)
                S_START: begin
                    r_Cnt <= (r_Cnt == c_CNT_MID) ? '0 : r_Cnt + 1'b1;
                end
                S_DATA: begin
                    if (w_Slot_End) begin
                        r_Cnt   <= '0;
                        r_Shift <= {r_Rx_Sync, r_Shift[DATA_BITS-1:1]};
                        r_Idx   <= (r_Idx == c_DATA_LAST) ? '0 : r_Idx + 1'b1;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_Slot_End) begin
                        r_Cnt     <= '0;
                        r_Par_Bit <= r_Rx_Sync;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_Slot_End) begin
                        r_Cnt <= '0;
                        r_Idx <= r_Idx + 1'b1;
                        if (!r_Rx_Sync) begin
                            r_Stop_Err <= 1'b1;
                        end
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                    if (w_Last_Stop) begin
                        r_Rx_DV      <= 1'b1;
                        r_Rx_Data    <= r_Shift;
                        r_Parity_Err <= w_Par_Err;
                        r_Frame_Err  <= r_Stop_Err | ~r_Rx_Sync;
                    end
                end
                default: begin
                    r_Cnt      <= '0;
                    r_Idx      <= '0;
                    r_Stop_Err <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic r_All_Zero;
    logic r_Break;

    // r_All_Zero stays set only while every data/parity/stop sample is low.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_All_Zero <= 1'b1;
            r_Break    <= 1'b0;
        end else begin
            case (r_State)
                S_IDLE: r_All_Zero <= 1'b1;
                S_DATA, S_PARITY: begin
                    if (w_Slot_End && r_Rx_Sync) begin
                        r_All_Zero <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_Slot_End && r_Rx_Sync) begin
                        r_All_Zero <= 1'b0;
                    end
                    if (w_Last_Stop) begin
                        r_Break <= r_All_Zero & ~r_Rx_Sync;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_Rx_Sync) begin
                        r_Break <= 1'b0;
                    end
                end
                default: begin
                    r_All_Zero <= r_All_Zero;
                end
            endcase
        end
    end

    assign o_Break = r_Break;
`else
    assign o_Break = 1'b0;
`endif

    assign o_Rx_DV      = r_Rx_DV;
    assign o_Rx_Data    = r_Rx_Data;
    assign o_Parity_Err = r_Parity_Err;
    assign o_Frame_Err  = r_Frame_Err;
    assign o_Busy       = (r_State != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// Bench for uart_rx_param: 8N1, 8E1 and 7O2 instances sharing one clock and reset.
module tb_uart_rx_param;
    localparam int CPB = 16;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic EXP_BRK = 1'b1;
`else
    localparam logic EXP_BRK = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rx_n = 1'b1;
    logic       rx_e = 1'b1;
    logic       rx_t = 1'b1;
    logic       n_dv, n_perr, n_ferr, n_busy, n_brk;
    logic [7:0] n_data;
    logic       e_dv, e_perr, e_ferr, e_busy, e_brk;
    logic [7:0] e_data;
    logic       t_dv, t_perr, t_ferr, t_busy, t_brk;
    logic [6:0] t_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int n_dv_cnt = 0;
    int e_dv_cnt = 0;
    int t_dv_cnt = 0;
    int n_dv_cyc = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_n), .o_Rx_DV(n_dv), .o_Rx_Data(n_data),
        .o_Parity_Err(n_perr), .o_Frame_Err(n_ferr), .o_Busy(n_busy), .o_Break(n_brk));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_e), .o_Rx_DV(e_dv), .o_Rx_Data(e_data),
        .o_Parity_Err(e_perr), .o_Frame_Err(e_ferr), .o_Busy(e_busy), .o_Break(e_brk));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_t), .o_Rx_DV(t_dv), .o_Rx_Data(t_data),
        .o_Parity_Err(t_perr), .o_Frame_Err(t_ferr), .o_Busy(t_busy), .o_Break(t_brk));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (n_dv) begin
            n_dv_cnt <= n_dv_cnt + 1;
            n_dv_cyc <= cyc;
        end
        if (e_dv) e_dv_cnt <= e_dv_cnt + 1;
        if (t_dv) t_dv_cnt <= t_dv_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives nbits LSB-first, one bit slot each; the line keeps the last bit afterwards.
    task automatic send_raw(input int sel, input logic [15:0] bits, input int nbits);
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            case (sel)
                0:       rx_n = bits[i];
                1:       rx_e = bits[i];
                default: rx_t = bits[i];
            endcase
            tick(CPB);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        checks++; if ({n_dv, n_perr, n_ferr, n_busy, n_brk, n_data} !== 13'h0) begin failures++; $display("FAIL reset_8n1: got %h expected 0", {n_dv, n_perr, n_ferr, n_busy, n_brk, n_data}); end
        checks++; if ({e_dv, e_perr, e_ferr, e_busy, e_brk, e_data} !== 13'h0) begin failures++; $display("FAIL reset_8e1: got %h expected 0", {e_dv, e_perr, e_ferr, e_busy, e_brk, e_data}); end
        checks++; if ({t_dv, t_perr, t_ferr, t_busy, t_brk, t_data} !== 12'h0) begin failures++; $display("FAIL reset_7o2: got %h expected 0", {t_dv, t_perr, t_ferr, t_busy, t_brk, t_data}); end
        rst = 1'b0;
        tick(4);
        checks++; if ({n_busy, e_busy, t_busy} !== 3'b000) begin failures++; $display("FAIL reset_idle_busy: got %b expected 000", {n_busy, e_busy, t_busy}); end
    endtask

    task automatic test_8n1;
        int lat;
        send_raw(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
        tick(8);
        lat = n_dv_cyc - start_cyc;
        checks++; if (n_dv_cnt !== 1) begin failures++; $display("FAIL 8n1_dv_count: got %0d expected 1", n_dv_cnt); end
        checks++; if (n_data !== 8'hA5) begin failures++; $display("FAIL 8n1_data: got %h expected a5", n_data); end
        checks++; if (n_perr !== 1'b0) begin failures++; $display("FAIL 8n1_perr: got %b expected 0", n_perr); end
        checks++; if (n_ferr !== 1'b0) begin failures++; $display("FAIL 8n1_ferr: got %b expected 0", n_ferr); end
        checks++; if (lat < 154 || lat > 156) begin failures++; $display("FAIL 8n1_latency: got %0d expected 155", lat); end
        checks++; if (n_busy !== 1'b0) begin failures++; $display("FAIL 8n1_busy_after: got %b expected 0", n_busy); end
    endtask

    task automatic test_back_to_back;
        int base;
        base = n_dv_cnt;
        send_raw(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
        checks++; if (n_data !== 8'h3C) begin failures++; $display("FAIL b2b_first_data: got %h expected 3c", n_data); end
        checks++; if (n_dv_cnt !== base + 1) begin failures++; $display("FAIL b2b_first_count: got %0d expected %0d", n_dv_cnt, base + 1); end
        send_raw(0, 16'({1'b1, 8'hC3, 1'b0}), 10);
        tick(4);
        checks++; if (n_data !== 8'hC3) begin failures++; $display("FAIL b2b_second_data: got %h expected c3", n_data); end
        checks++; if (n_dv_cnt !== base + 2) begin failures++; $display("FAIL b2b_second_count: got %0d expected %0d", n_dv_cnt, base + 2); end
    endtask

    task automatic test_glitch;
        int base;
        base = n_dv_cnt;
        rx_n = 1'b0;
        tick(5);
        checks++; if (n_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_start: got %b expected 1", n_busy); end
        rx_n = 1'b1;
        tick(7);
        checks++; if (n_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_return: got %b expected 0", n_busy); end
        tick(200);
        checks++; if (n_dv_cnt !== base) begin failures++; $display("FAIL glitch_no_dv: got %0d expected %0d", n_dv_cnt, base); end
        checks++; if ({n_data, n_ferr, n_perr} !== {8'hC3, 1'b0, 1'b0}) begin failures++; $display("FAIL glitch_flags_hold: got %h expected %h", {n_data, n_ferr, n_perr}, {8'hC3, 2'b00}); end
    endtask

    task automatic test_parity_even;
        send_raw(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
        tick(8);
        checks++; if (e_dv_cnt !== 1) begin failures++; $display("FAIL 8e1_bad_count: got %0d expected 1", e_dv_cnt); end
        checks++; if (e_data !== 8'h03) begin failures++; $display("FAIL 8e1_bad_data: got %h expected 03", e_data); end
        checks++; if (e_perr !== 1'b1) begin failures++; $display("FAIL 8e1_bad_perr: got %b expected 1", e_perr); end
        checks++; if (e_ferr !== 1'b0) begin failures++; $display("FAIL 8e1_bad_ferr: got %b expected 0", e_ferr); end
        send_raw(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
        tick(8);
        checks++; if (e_dv_cnt !== 2) begin failures++; $display("FAIL 8e1_good_count: got %0d expected 2", e_dv_cnt); end
        checks++; if ({e_data, e_perr} !== {8'h03, 1'b0}) begin failures++; $display("FAIL 8e1_good_perr: got %h expected 006", {e_data, e_perr}); end
    endtask

    task automatic test_frame_err_7o2;
        send_raw(2, 16'({1'b0, 1'b1, 1'b1, 7'h41, 1'b0}), 11);
        tick(48);
        checks++; if (t_dv_cnt !== 1) begin failures++; $display("FAIL 7o2_count: got %0d expected 1", t_dv_cnt); end
        checks++; if (t_data !== 7'h41) begin failures++; $display("FAIL 7o2_data: got %h expected 41", t_data); end
        checks++; if (t_ferr !== 1'b1) begin failures++; $display("FAIL 7o2_ferr: got %b expected 1", t_ferr); end
        checks++; if (t_perr !== 1'b0) begin failures++; $display("FAIL 7o2_perr: got %b expected 0", t_perr); end
        checks++; if (t_busy !== 1'b1) begin failures++; $display("FAIL 7o2_wait_high_busy: got %b expected 1", t_busy); end
        rx_t = 1'b1;
        tick(6);
        checks++; if (t_busy !== 1'b0) begin failures++; $display("FAIL 7o2_idle_after_high: got %b expected 0", t_busy); end
        checks++; if (t_dv_cnt !== 1) begin failures++; $display("FAIL 7o2_no_extra_dv: got %0d expected 1", t_dv_cnt); end
    endtask

    task automatic test_break;
        int base;
        base = n_dv_cnt;
        rx_n = 1'b0;
        tick(20 * CPB);
        checks++; if (n_dv_cnt !== base + 1) begin failures++; $display("FAIL break_count: got %0d expected %0d", n_dv_cnt, base + 1); end
        checks++; if (n_data !== 8'h00) begin failures++; $display("FAIL break_data: got %h expected 00", n_data); end
        checks++; if (n_ferr !== 1'b1) begin failures++; $display("FAIL break_ferr: got %b expected 1", n_ferr); end
        checks++; if (n_brk !== EXP_BRK) begin failures++; $display("FAIL break_flag: got %b expected %b", n_brk, EXP_BRK); end
        checks++; if (n_busy !== 1'b1) begin failures++; $display("FAIL break_busy: got %b expected 1", n_busy); end
        rx_n = 1'b1;
        tick(2);
        checks++; if (n_brk !== EXP_BRK) begin failures++; $display("FAIL break_hold: got %b expected %b", n_brk, EXP_BRK); end
        tick(2);
        checks++; if (n_brk !== 1'b0) begin failures++; $display("FAIL break_clear: got %b expected 0", n_brk); end
        checks++; if (n_busy !== 1'b0) begin failures++; $display("FAIL break_idle: got %b expected 0", n_busy); end
    endtask

    task automatic test_reset_midframe;
        int base;
        base = n_dv_cnt;
        send_raw(0, 16'({1'b1, 8'hFF, 1'b0}), 5);
        rx_n = 1'b1;
        tick(8);
        checks++; if (n_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", n_busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if ({n_dv, n_perr, n_ferr, n_busy, n_brk, n_data} !== 13'h0) begin failures++; $display("FAIL midrst_cleared: got %h expected 0", {n_dv, n_perr, n_ferr, n_busy, n_brk, n_data}); end
        tick(200);
        checks++; if (n_dv_cnt !== base) begin failures++; $display("FAIL midrst_no_dv: got %0d expected %0d", n_dv_cnt, base); end
        send_raw(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
        tick(4);
        checks++; if (n_dv_cnt !== base + 1) begin failures++; $display("FAIL midrst_next_count: got %0d expected %0d", n_dv_cnt, base + 1); end
        checks++; if ({n_data, n_ferr, n_perr} !== {8'h5A, 2'b00}) begin failures++; $display("FAIL midrst_next_data: got %h expected %h", {n_data, n_ferr, n_perr}, {8'h5A, 2'b00}); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_back_to_back();
        test_glitch();
        test_parity_even();
        test_frame_err_7o2();
        test_break();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
